// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_reg_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_DATA  = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RD_DUMMY = 2'd3
  } state_t;

  // Command byte bit selecting write (1) or read (0)
  localparam int unsigned CMD_WR_BIT = 7;

  // Response byte returned when a read never completes
  localparam logic [7:0] RD_TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/spi_rx_edge.sv
// Rising-edge detector on the synchronized rx_ready level. Flags one event
// per new byte and presents the byte alongside it for the consumer to capture.
module spi_rx_edge #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ev_c,
  output logic [DATA_W-1:0] rx_byte_c
);

  logic rx_ready_q;

  // Delayed copy of rx_ready for edge detection
  always_ff @(posedge clk_sys) begin
    if (!rst_n) rx_ready_q <= 1'b0;
    else        rx_ready_q <= rx_ready;
  end

  // Event in the cycle rx_ready rises; byte is stable while rx_ready is high
  assign rx_ev_c   = rx_ready & ~rx_ready_q;
  assign rx_byte_c = rx_data;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller: decodes 2-byte frames from the SPI slave
// into register read/write strobes and loads the read response for transmit.
// Optional burst mode (auto-incrementing address) when SPI_REG_AUTOINC_EN
// is defined; single-transfer frames otherwise.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rvalid,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYC + 1);

  state_t                state;
  logic [TIMEOUT_W-1:0]  tmo_cnt;
  logic                  tmo_hit_c;
  logic                  rx_ev_c;
  logic [DATA_W-1:0]     rx_byte_c;
`ifdef SPI_REG_AUTOINC_EN
  logic                  wr_more;
`endif

  spi_rx_edge #(.DATA_W(DATA_W)) u_rx_edge (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_ev_c   (rx_ev_c),
    .rx_byte_c (rx_byte_c)
  );

  // Frame abandoned once the counter reaches the limit without a byte
  assign tmo_hit_c = (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYC));

  // Frame FSM, idle timeout and registered strobes/outputs
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      tx_data   <= '0;
      tx_load   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_REG_AUTOINC_EN
      wr_more   <= 1'b0;
`endif
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      tx_load <= 1'b0;

      // Clear first so a same-cycle error set below takes priority
      if (err_clr) frame_err <= 1'b0;

      if (rx_ev_c || (state == ST_IDLE)) tmo_cnt <= '0;
      else if (!tmo_hit_c)               tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);

      case (state)
        ST_IDLE: begin
          if (rx_ev_c) begin
            reg_addr <= rx_byte_c[ADDR_W-1:0];
`ifdef SPI_REG_AUTOINC_EN
            wr_more  <= 1'b0;
`endif
            if (rx_byte_c[CMD_WR_BIT]) begin
              state <= ST_WR_DATA;
            end else begin
              reg_re <= 1'b1;
              state  <= ST_RD_WAIT;
            end
          end
        end

        ST_WR_DATA: begin
          if (rx_ev_c) begin
            reg_wdata <= rx_byte_c;
            reg_we    <= 1'b1;
`ifdef SPI_REG_AUTOINC_EN
            if (wr_more) reg_addr <= reg_addr + ADDR_W'(1);
            wr_more <= 1'b1;
`else
            state <= ST_IDLE;
`endif
          end else if (tmo_hit_c) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
`ifndef SPI_REG_AUTOINC_EN
            frame_err <= 1'b1;
`endif
          end
        end

        ST_RD_WAIT: begin
          if (rx_ev_c) begin
            // Master outran the read: drop the byte and the pending response
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (reg_rvalid) begin
            tx_data <= reg_rdata;
            tx_load <= 1'b1;
            state   <= ST_RD_DUMMY;
            tmo_cnt <= '0;
          end else if (tmo_hit_c) begin
            tx_data   <= RD_TIMEOUT_FILL;
            tx_load   <= 1'b1;
            frame_err <= 1'b1;
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
          end
        end

        ST_RD_DUMMY: begin
          if (rx_ev_c) begin
`ifdef SPI_REG_AUTOINC_EN
            reg_addr <= reg_addr + ADDR_W'(1);
            reg_re   <= 1'b1;
            state    <= ST_RD_WAIT;
`else
            state <= ST_IDLE;
`endif
          end else if (tmo_hit_c) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
`ifndef SPI_REG_AUTOINC_EN
            frame_err <= 1'b1;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- clk_sys-domain controller that sequences the SPI slave receive/transmit datapath into a simple register-access protocol.
- Consumes synchronized received bytes (rx_data/rx_ready from the SPI slave sync stage) and decodes 2-byte frames into register-bus read/write strobes.
- Loads the response byte into the slave's transmit path.
- Frames are resynchronized by an idle timeout, since the SPI link carries no chip-select.

Parameters:
- ADDR_W, 7, register address width; must equal 7 (the command byte holds a 1-bit opcode plus the address).
- DATA_W, 8, register data width; must equal 8 (one SPI byte).
- TIMEOUT_CYC, 1024, clk_sys cycles without a new byte (in any non-IDLE state) before the frame is abandoned.
- TIMEOUT_W, $clog2(TIMEOUT_CYC+1), timeout counter width (derived, not overridden).

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  received byte, stable while rx_ready high
- rx_ready  in  1  level from sync stage; a rising edge marks one new byte
- tx_data  out  8  response byte to SPI slave transmit register
- tx_load  out  1  one-cycle pulse: tx_data valid, load it
- reg_addr  out  7  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid with reg_rvalid
- reg_rvalid  in  1  read completion pulse
- frame_err  out  1  sticky error flag
- err_clr  in  1  clears frame_err

Behaviour:
- Reset (rst_n=0 at a clk_sys edge): state IDLE; edge-detect flop 0; timeout counter 0; all outputs 0 (tx_data=8'h00, reg_addr=0, reg_wdata=0, strobes 0, frame_err 0).
- Reset mid-frame aborts the frame silently; no strobe is issued.
- Byte event: rx_ev = rx_ready & ~rx_ready_q, where rx_ready_q is registered. rx_data is captured on the rx_ev cycle (cycle N). All strobes are registered and assert at N+1 for exactly one cycle.
- Command byte: bit7=1 means write, bit7=0 means read; bits[6:0] are the address.
- FSM states: IDLE, WR_DATA, RD_WAIT, RD_DUMMY.
  - IDLE: on rx_ev latch reg_addr. Write: go to WR_DATA. Read: pulse reg_re at N+1 and go to RD_WAIT.
  - WR_DATA: on rx_ev, reg_wdata<=rx_data, pulse reg_we at N+1, go to IDLE.
  - RD_WAIT: on reg_rvalid, tx_data<=reg_rdata, pulse tx_load next cycle, go to RD_DUMMY. If reg_rvalid arrives in the same cycle as the reg_re pulse, it is accepted.
  - RD_DUMMY: on rx_ev (the master's clock-out byte), discard the byte and go to IDLE.
- Timeout counter:
  - Cleared on every rx_ev and on every state change; counts only in non-IDLE states; saturates.
  - At TIMEOUT_CYC: go to IDLE, set frame_err.
  - In RD_WAIT, additionally load tx_data=8'hFF and pulse tx_load.
- Simultaneous events:
  - rx_ev in the same cycle as timeout expiry: rx_ev wins (counter cleared, byte processed).
  - rx_ev during RD_WAIT (master outran the read): set frame_err, discard the byte, go to IDLE; a later reg_rvalid is ignored.
- frame_err is sticky; err_clr clears it. A set and a clear in the same cycle results in set.
- Strobes never overlap; at most one of reg_we/reg_re/tx_load is high per cycle.

Optional Feature:
- SPI_REG_AUTOINC_EN defined (burst mode):
  - After a write, WR_DATA stays active. Each further rx_ev writes to reg_addr+1, wrapping 7'h7F to 7'h00.
  - Reads likewise re-issue reg_re at addr+1 after each RD_DUMMY byte, instead of returning to IDLE.
  - In WR_DATA and RD_DUMMY, timeout ends the burst and returns to IDLE without setting frame_err. Timeout in RD_WAIT still sets frame_err.
- Undefined: single-transfer behaviour as above.

Decomposition:
- Package spi_reg_pkg holds: state enum typedef, CMD_WR_BIT=7, RD_TIMEOUT_FILL=8'hFF.
- Sub-module spi_rx_edge: registered rising-edge detector plus data capture producing rx_ev/rx_byte. This sub-module is natural and reusable for other consumers of the sync stage.

Test Plan:
- Write: bytes 8'h85, 8'h3C -> one reg_we cycle with reg_addr=7'h05, reg_wdata=8'h3C, one cycle after the second rx_ev; frame_err=0.
- Read: byte 8'h12; reg_rvalid with reg_rdata=8'hA5 three cycles after reg_re -> reg_re with addr 7'h12, then tx_load with tx_data=8'hA5; a dummy byte returns the FSM to IDLE.
- Timeout: byte 8'h81 then silence for TIMEOUT_CYC -> no reg_we, frame_err=1; err_clr -> 0; the next frame 8'h81, 8'h00 writes normally.
- Read stall: byte 8'h20 with reg_rvalid never asserted -> after TIMEOUT_CYC, tx_load with tx_data=8'hFF and frame_err=1.
- Overrun/simultaneity: rx_ev in RD_WAIT -> frame_err=1, byte discarded. rx_ev exactly on the expiry cycle in WR_DATA -> write completes, no error.
- Reset mid-frame, and with SPI_REG_AUTOINC_EN: rst_n low after 8'h85 -> outputs 0, no write. Burst 8'hFF, 8'h01, 8'h02 -> writes to 7'h7F then 7'h00, no error at timeout.
